// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered prioritised interrupt controller; register port acks 1 cycle after req_i, never stalls.
// Source-to-irq_o latency is 2 edges, or 4 edges with IRQ_CTRL_SYNC_EN defined (2-flop input synchroniser).
module irq_ctrl #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  src_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [3:0]          addr_i,
   input  logic [31:0]         wdata_i,
   output logic [31:0]         rdata_o,
   output logic                ack_o,
   output logic                irq_o,
   output logic [ID_W-1:0]     irq_id_o
);

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_ENABLE  = 2'd1;
   localparam logic [1:0] REG_CLAIM   = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   logic [NUM_SRC-1:0] src_s;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] src_edge;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] enable;
   logic               in_service;
   logic [ID_W-1:0]    active_id;

   logic [NUM_SRC-1:0] masked;
   logic [NUM_SRC-1:0] winner_oh;
   logic [ID_W-1:0]    cand_id;
   logic [1:0]         sel;
   logic               rd;
   logic               wr;
   logic               claim_ok;
   logic               complete_ok;
   logic [NUM_SRC-1:0] w1c_clr;
   logic [NUM_SRC-1:0] claim_clr;
   logic [31:0]        rdata_nxt;
   logic               unused_ok;

`ifdef IRQ_CTRL_SYNC_EN
   logic [NUM_SRC-1:0] sync_a;
   logic [NUM_SRC-1:0] sync_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= src_i;
         sync_b <= sync_a;
      end
   end

   assign src_s = sync_b;
`else
   assign src_s = src_i;
`endif

   assign src_edge = src_s & ~src_q;
   assign masked   = pending & enable;
   // Isolate the lowest set bit: lowest index has highest priority.
   assign winner_oh = masked & ~(masked - NUM_SRC'(1));

   always_comb begin
      cand_id = '0;
      for (int n = NUM_SRC - 1; n >= 0; n--) begin
         if (masked[n]) cand_id = ID_W'(n + 1);
      end
   end

   assign sel         = addr_i[3:2];
   assign rd          = req_i & ~we_i;
   assign wr          = req_i & we_i;
   assign claim_ok    = rd && (sel == REG_CLAIM) && !in_service && (|masked);
   assign complete_ok = wr && (sel == REG_CLAIM) && in_service &&
                        (wdata_i[ID_W-1:0] == active_id);
   assign w1c_clr     = (wr && sel == REG_PENDING) ? wdata_i[NUM_SRC-1:0] : '0;
   assign claim_clr   = claim_ok ? winner_oh : '0;

   always_comb begin
      rdata_nxt = '0;
      if (rd) begin
         case (sel)
            REG_PENDING: rdata_nxt = 32'(pending);
            REG_ENABLE:  rdata_nxt = 32'(enable);
            REG_CLAIM:   rdata_nxt = claim_ok ? 32'(cand_id) : 32'd0;
            REG_STATUS: begin
               rdata_nxt     = 32'(active_id);
               rdata_nxt[31] = in_service;
            end
            default:     rdata_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q      <= '0;
         pending    <= '0;
         enable     <= '0;
         in_service <= 1'b0;
         active_id  <= '0;
      end else begin
         src_q <= src_s;
         // A new edge wins over any clear landing on the same bit.
         pending <= (pending & ~w1c_clr & ~claim_clr) | src_edge;
         if (wr && sel == REG_ENABLE) enable <= wdata_i[NUM_SRC-1:0];
         if (claim_ok) begin
            in_service <= 1'b1;
            active_id  <= cand_id;
         end else if (complete_ok) begin
            in_service <= 1'b0;
            active_id  <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_o  <= '0;
         ack_o    <= 1'b0;
         irq_o    <= 1'b0;
         irq_id_o <= '0;
      end else begin
         rdata_o  <= rdata_nxt;
         ack_o    <= req_i;
         irq_o    <= (|masked) & ~in_service;
         irq_id_o <= cand_id;
      end
   end

   assign unused_ok = ^{addr_i[1:0], wdata_i[31:NUM_SRC]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, multi-cycle reset/latency sequences, then random traffic vs a reference model.
module tb_irq_ctrl;
   localparam int NUM_SRC = 4;
   localparam int ID_W    = 3;
`ifdef IRQ_CTRL_SYNC_EN
   localparam int XL = 2;
`else
   localparam int XL = 0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NUM_SRC-1:0] src_i = '0;
   logic               req_i = 1'b0;
   logic               we_i = 1'b0;
   logic [3:0]         addr_i = '0;
   logic [31:0]        wdata_i = '0;
   logic [31:0]        rdata_o;
   logic               ack_o;
   logic               irq_o;
   logic [ID_W-1:0]    irq_id_o;

   always #5 clk = ~clk;

   irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
      .clk(clk), .rst(rst), .src_i(src_i), .req_i(req_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o),
      .irq_o(irq_o), .irq_id_o(irq_id_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bus/source cycle: drive just after an edge, sample 1ns after the next edge.
   task automatic cyc(input logic [3:0] s, input logic r, input logic w,
                      input logic [3:0] a, input logic [31:0] d);
      src_i = s; req_i = r; we_i = w; addr_i = a; wdata_i = d;
      @(posedge clk);
      #1;
      req_i = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  src;
      logic        req;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] rdata;
      logic        irq;
      logic [2:0]  id;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic [3:0] s, input logic r, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic k, input logic [31:0] rd,
                      input logic q, input logic [2:0] id);
      vec_t v;
      v.src = s; v.req = r; v.we = w; v.addr = a; v.wdata = d;
      v.ack = k; v.rdata = rd; v.irq = q; v.id = id;
      tv.push_back(v);
   endtask

   // Reference model: per-source bit arrays, sources seen through an XL-cycle delay line.
   bit m_pend[NUM_SRC];
   bit m_en[NUM_SRC];
   bit m_prev[NUM_SRC];
   bit m_d1[NUM_SRC];
   bit m_d2[NUM_SRC];
   bit m_busy;
   int m_active;

   task automatic model_reset();
      for (int n = 0; n < NUM_SRC; n++) begin
         m_pend[n] = 0; m_en[n] = 0; m_prev[n] = 0; m_d1[n] = 0; m_d2[n] = 0;
      end
      m_busy = 0;
      m_active = 0;
   endtask

   function automatic int m_winner();
      for (int n = 0; n < NUM_SRC; n++)
         if (m_pend[n] && m_en[n]) return n + 1;
      return 0;
   endfunction

   task automatic model_step(input logic [3:0] s, input logic r, input logic w,
                             input logic [3:0] a, input logic [31:0] d,
                             output logic e_ack, output logic [31:0] e_rdata,
                             output logic e_irq, output logic [2:0] e_id);
      int win;
      bit eff[NUM_SRC];
      win = m_winner();
      e_irq = (win != 0) && !m_busy;
      e_id = 3'(win);
      e_ack = r;
      e_rdata = 0;
      for (int n = 0; n < NUM_SRC; n++) eff[n] = (XL != 0) ? m_d2[n] : s[n];
      if (r && !w) begin
         case (a[3:2])
            2'd0: for (int n = 0; n < NUM_SRC; n++) if (m_pend[n]) e_rdata += 32'(1 << n);
            2'd1: for (int n = 0; n < NUM_SRC; n++) if (m_en[n]) e_rdata += 32'(1 << n);
            2'd2: if (!m_busy && win != 0) begin
               e_rdata = 32'(win);
               m_pend[win-1] = 0;
               m_busy = 1;
               m_active = win;
            end
            default: e_rdata = (m_busy ? 32'h8000_0000 : 32'h0) + 32'(m_active);
         endcase
      end else if (r && w) begin
         case (a[3:2])
            2'd0: for (int n = 0; n < NUM_SRC; n++) if (d[n]) m_pend[n] = 0;
            2'd1: for (int n = 0; n < NUM_SRC; n++) m_en[n] = d[n];
            2'd2: if (m_busy && int'(d % 8) == m_active) begin
               m_busy = 0;
               m_active = 0;
            end
            default: ;
         endcase
      end
      for (int n = 0; n < NUM_SRC; n++) begin
         if (eff[n] && !m_prev[n]) m_pend[n] = 1;
         m_prev[n] = eff[n];
         m_d2[n] = m_d1[n];
         m_d1[n] = s[n];
      end
   endtask

   initial begin
      logic        e_ack, e_irq;
      logic [31:0] e_rdata;
      logic [2:0]  e_id;
      logic [3:0]  rs;

      repeat (3) @(posedge clk);
      #1;
      chk("reset rdata", rdata_o, 32'h0);
      chk("reset ack", ack_o, 32'h0);
      chk("reset irq", irq_o, 32'h0);
      chk("reset irq_id", irq_id_o, 32'h0);
      rst = 1'b0;

`ifndef IRQ_CTRL_SYNC_EN
      //   src  req we addr wdata            ack rdata          irq id
      add(4'h0, 1, 1, 4'h4, 32'h3,          1, 32'h0,         0, 0);
      add(4'h2, 0, 0, 4'h0, 32'h0,          0, 32'h0,         0, 0);
      add(4'h0, 0, 0, 4'h0, 32'h0,          0, 32'h0,         1, 2);
      add(4'h0, 1, 0, 4'h0, 32'h0,          1, 32'h2,         1, 2);
      add(4'h0, 1, 0, 4'hC, 32'h0,          1, 32'h0,         1, 2);
      add(4'h0, 1, 1, 4'h0, 32'h2,          1, 32'h0,         1, 2);
      add(4'h0, 1, 1, 4'h4, 32'hF,          1, 32'h0,         0, 0);
      add(4'h3, 0, 0, 4'h0, 32'h0,          0, 32'h0,         0, 0);
      add(4'h0, 0, 0, 4'h0, 32'h0,          0, 32'h0,         1, 1);
      add(4'h0, 1, 0, 4'h8, 32'h0,          1, 32'h1,         1, 1);
      add(4'h0, 1, 0, 4'hC, 32'h0,          1, 32'h8000_0001, 0, 2);
      add(4'h0, 1, 0, 4'h8, 32'h0,          1, 32'h0,         0, 2);
      add(4'h0, 1, 1, 4'h8, 32'h3,          1, 32'h0,         0, 2);
      add(4'h0, 1, 0, 4'hC, 32'h0,          1, 32'h8000_0001, 0, 2);
      add(4'h0, 1, 1, 4'h8, 32'h1,          1, 32'h0,         0, 2);
      add(4'h0, 1, 0, 4'hC, 32'h0,          1, 32'h0,         1, 2);
      add(4'h0, 1, 0, 4'h8, 32'h0,          1, 32'h2,         1, 2);
      add(4'h0, 1, 1, 4'h8, 32'h2,          1, 32'h0,         0, 0);
      add(4'h0, 1, 1, 4'h4, 32'h0,          1, 32'h0,         0, 0);
      add(4'h4, 0, 0, 4'h0, 32'h0,          0, 32'h0,         0, 0);
      add(4'h0, 0, 0, 4'h0, 32'h0,          0, 32'h0,         0, 0);
      add(4'h0, 1, 1, 4'h4, 32'h4,          1, 32'h0,         0, 0);
      add(4'h0, 0, 0, 4'h0, 32'h0,          0, 32'h0,         1, 3);
      add(4'h0, 1, 1, 4'h0, 32'h4,          1, 32'h0,         1, 3);
      add(4'h0, 1, 0, 4'h0, 32'h0,          1, 32'h0,         0, 0);
      add(4'h4, 0, 0, 4'h0, 32'h0,          0, 32'h0,         0, 0);
      add(4'h0, 0, 0, 4'h0, 32'h0,          0, 32'h0,         1, 3);
      add(4'h4, 1, 1, 4'h0, 32'h4,          1, 32'h0,         1, 3);
      add(4'h4, 1, 0, 4'h0, 32'h0,          1, 32'h4,         1, 3);
      add(4'h4, 1, 1, 4'h0, 32'h4,          1, 32'h0,         1, 3);
      add(4'h4, 1, 0, 4'h0, 32'h0,          1, 32'h0,         0, 0);
      add(4'h4, 0, 0, 4'h0, 32'h0,          0, 32'h0,         0, 0);
      add(4'h0, 0, 0, 4'h0, 32'h0,          0, 32'h0,         0, 0);
      add(4'h4, 0, 0, 4'h0, 32'h0,          0, 32'h0,         0, 0);
      add(4'h0, 0, 0, 4'h0, 32'h0,          0, 32'h0,         1, 3);
      add(4'h4, 1, 0, 4'h8, 32'h0,          1, 32'h3,         1, 3);
      add(4'h4, 1, 0, 4'h0, 32'h0,          1, 32'h4,         0, 3);
      add(4'h0, 1, 1, 4'h8, 32'h3,          1, 32'h0,         0, 3);
      add(4'h0, 1, 0, 4'h0, 32'h0,          1, 32'h4,         1, 3);
      add(4'h0, 1, 1, 4'h4, 32'hFFFF_FFFF,  1, 32'h0,         1, 3);
      add(4'h0, 1, 0, 4'h5, 32'h0,          1, 32'hF,         1, 3);
      for (int i = 0; i < tv.size(); i++) begin
         cyc(tv[i].src, tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata);
         chk($sformatf("vec%0d ack", i), ack_o, tv[i].ack);
         chk($sformatf("vec%0d rdata", i), rdata_o, tv[i].rdata);
         chk($sformatf("vec%0d irq", i), irq_o, tv[i].irq);
         chk($sformatf("vec%0d irq_id", i), irq_id_o, tv[i].id);
      end
`else
      // Synchronised build: irq_o must appear exactly at the 4th edge after the pulse.
      cyc(4'h0, 1, 1, 4'h4, 32'h3);
      cyc(4'h2, 0, 0, 4'h0, 32'h0);
      chk("sync edge1 irq", irq_o, 32'h0);
      cyc(4'h0, 0, 0, 4'h0, 32'h0);
      chk("sync edge2 irq", irq_o, 32'h0);
      cyc(4'h0, 0, 0, 4'h0, 32'h0);
      chk("sync edge3 irq", irq_o, 32'h0);
      cyc(4'h0, 0, 0, 4'h0, 32'h0);
      chk("sync edge4 irq", irq_o, 32'h1);
      chk("sync edge4 irq_id", irq_id_o, 32'h2);
      cyc(4'h0, 1, 0, 4'h0, 32'h0);
      chk("sync pending", rdata_o, 32'h2);
`endif

      // Mid-operation reset with one source in service and all pending.
      cyc(4'h0, 1, 1, 4'h4, 32'hF);
      cyc(4'h0, 1, 1, 4'h0, 32'hF);
      cyc(4'hF, 0, 0, 4'h0, 32'h0);
      repeat (1 + XL) cyc(4'h0, 0, 0, 4'h0, 32'h0);
      cyc(4'h0, 1, 0, 4'h8, 32'h0);
      chk("mid claim", rdata_o, 32'h1);
      cyc(4'hF, 0, 0, 4'h0, 32'h0);
      repeat (1 + XL) cyc(4'h0, 0, 0, 4'h0, 32'h0);
      cyc(4'h0, 1, 0, 4'h0, 32'h0);
      chk("mid pending", rdata_o, 32'hF);
      chk("mid ack", ack_o, 32'h1);
      chk("mid irq", irq_o, 32'h0);
      chk("mid irq_id", irq_id_o, 32'h1);
      rst = 1'b1;
      src_i = 4'h1;
      #1;
      chk("arst rdata", rdata_o, 32'h0);
      chk("arst ack", ack_o, 32'h0);
      chk("arst irq", irq_o, 32'h0);
      chk("arst irq_id", irq_id_o, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (1 + XL) cyc(4'h1, 0, 0, 4'h0, 32'h0);
      cyc(4'h1, 1, 0, 4'h0, 32'h0);
      chk("post-reset pending", rdata_o, 32'h1);
      cyc(4'h1, 1, 0, 4'hC, 32'h0);
      chk("post-reset status", rdata_o, 32'h0);
      cyc(4'h1, 1, 0, 4'h4, 32'h0);
      chk("post-reset enable", rdata_o, 32'h0);

      // Random traffic against the reference model.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      rs = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         logic        r, w;
         logic [3:0]  a;
         logic [31:0] d;
         if ($urandom_range(0, 3) == 0) rs = rs ^ 4'($urandom);
         r = 1'($urandom);
         w = 1'($urandom);
         a = 4'($urandom);
         d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
         model_step(rs, r, w, a, d, e_ack, e_rdata, e_irq, e_id);
         cyc(rs, r, w, a, d);
         chk($sformatf("rnd%0d ack", i), ack_o, e_ack);
         chk($sformatf("rnd%0d rdata", i), rdata_o, e_rdata);
         chk($sformatf("rnd%0d irq", i), irq_o, e_irq);
         chk($sformatf("rnd%0d irq_id", i), irq_id_o, e_id);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Edge-triggered interrupt controller that collects the DMA `int_o` lines (src 0 = DMA start, src 1 = DMA finish) plus other peripheral interrupt sources, and presents a single prioritised external interrupt to the CPU. The CPU accesses it through a simple single-cycle register port driven by the CPU-side bus bridge. It is the block directly downstream of the DMA interrupt outputs.

## Interface
- NUM_SRC, 4, number of interrupt sources, legal range 1..31
- ID_W, $clog2(NUM_SRC+1), width of a source ID; ID 0 means "none", source n has ID n+1
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- src_i  input  NUM_SRC  interrupt source lines, rising-edge sensitive
- req_i  input  1  register access request, one-cycle pulse
- we_i  input  1  1 = write, 0 = read; qualified by req_i
- addr_i  input  4  byte address; bits [3:2] select the register, bits [1:0] are ignored
- wdata_i  input  32  write data
- rdata_o  output  32  read data, valid while ack_o = 1, otherwise 0
- ack_o  output  1  access acknowledge, one-cycle pulse
- irq_o  output  1  external interrupt to CPU, registered
- irq_id_o  output  ID_W  ID of the highest-priority enabled pending source, 0 if none; registered

## Operation
- Register map:
  - 0x0 PENDING: reads the pending bits; a write of 1 clears the corresponding bit (W1C)
  - 0x4 ENABLE: read/write; bits at or above NUM_SRC read as 0
  - 0x8 CLAIM: a read claims; a write completes
  - 0xC STATUS: {30'b0... , in_service, active_id} with active_id in [ID_W-1:0] and in_service in bit 31
- Edge detect: src_q <= src_i; edge = src_i & ~src_q. pending[n] is set on an edge, independent of ENABLE.
- Priority: the lowest source index wins among pending & enable.
- Claim (read 0x8):
  - When in_service = 0 and a candidate exists, the read returns the winner's ID, clears its pending bit, sets in_service = 1 and sets active_id = ID.
  - Otherwise the read returns 0 and no state changes.
- Complete (write 0x8):
  - When wdata_i[ID_W-1:0] == active_id and in_service = 1, the write clears in_service and sets active_id to 0.
  - Otherwise the write is ignored.
- Only one interrupt is outstanding at a time; there is no nesting.
- irq_o = |(pending & enable) & ~in_service, registered. irq_id_o is the candidate ID, registered (it is computed regardless of in_service).

## Timing
- Reset: every register is cleared (src_q, pending, enable, in_service, active_id). rdata_o = 0, ack_o = 0, irq_o = 0, irq_id_o = 0.
- Register port: on req_i high in cycle t, ack_o = 1 in cycle t+1, with rdata_o valid for reads. The state update from a write or claim is visible from cycle t+1. Back-to-back requests every cycle are supported.
- Source latency: src_i rises before edge k, pending is set after edge k, and irq_o/irq_id_o update after edge k+1.
- Simultaneous edge and W1C clear on the same bit: the set wins and the bit stays pending.
- Simultaneous edge and claim clear on the same bit: the set wins, so the bit is re-pended.
- A source held high sets pending only once. It must fall and rise again to re-pend.
- Clearing ENABLE does not clear pending. irq_o drops one cycle after the ENABLE write takes effect.
- Reset asserted mid-operation clears everything immediately (asynchronous). Pending edges are lost. src_q resets to 0, so a source that is high when reset deasserts registers an edge on the first clock.

## Configuration
- IRQ_CTRL_SYNC_EN
  - Defined: src_i passes through a 2-flop synchroniser before edge detection. Source-to-pending latency grows by 2 cycles, and source-to-irq_o becomes 4 edges.
  - Undefined: src_i feeds edge detection directly. Sources must be synchronous to clk.
- The register port timing is identical in both builds.

## Test plan
- Reset behaviour, then enable: write ENABLE = 0x3, pulse src_i[1] for 1 cycle -> PENDING reads 0x2. irq_o = 1 and irq_id_o = 2 two edges after the pulse.
- Priority and claim: pulse src_i[0] and src_i[1] together, ENABLE = 0xF -> CLAIM read returns 1, STATUS reads 0x80000001, irq_o = 0. After a complete (write 1), irq_o = 1 and the next CLAIM returns 2.
- Claim edge cases:
  - A CLAIM while in_service returns 0 with no state change.
  - A complete with the wrong ID (write 3 while active_id = 1) is ignored, and STATUS is unchanged.
- Masking and W1C: pending 0x4 with ENABLE = 0 -> irq_o stays 0. Setting ENABLE = 0x4 gives irq_o = 1; a W1C write of 0x4 returns irq_o to 0 and PENDING to 0.
- Collision: a src_i[2] edge in the same cycle as a W1C write of 0x4 -> PENDING still reads 0x4. Holding src_i[2] high after the clear produces no new pending.
- Mid-operation reset: assert rst with in_service = 1 and pending = 0xF -> all outputs are 0 immediately. After release, a high src_i[0] re-pends it on the first clock. With IRQ_CTRL_SYNC_EN defined, repeat the latency test and expect irq_o at edge 4.
